mantle_get_idx_stream: RTL and testbench

MANTLE_GET_IDX_STREAM -- requirements
Module: mantle_get_idx_stream

---
 rtl/mantle_pkg.sv | 12 +
 rtl/mantle_get_idx_stream.sv | 84 ++++++++
 tb/tb_mantle_get_idx_stream.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mantle_pkg.sv
// Shared definitions for the mantle index-stream block: FSM state type and default sizes.
package mantle_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int N_DEF = 9;
  localparam int W_DEF = 32;

endpackage

// File: rtl/mantle_get_idx_stream.sv
// Captures an N-element array and streams elements start_idx..N-1 out as valid/ready beats.
// Optional macro MANTLE_GET_IDX_LAST_EN adds an out_last flag on the final (idx=N-1) beat.
module mantle_get_idx_stream
  import mantle_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF,
  localparam int IW = $clog2(N + 1),
  localparam int OW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  in [N],
  input  logic [IW-1:0] start_idx,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_data,
  output logic [OW-1:0] out_idx,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef MANTLE_GET_IDX_LAST_EN
  output logic          out_last,
`endif
  output state_t        state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; out_data/out_idx are held while out_valid=1 and out_ready=0.

  localparam logic [IW-1:0] N_IDX    = IW'(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t        next_state;
  logic [W-1:0]  arr [N];
  logic [IW-1:0] idx;
  logic          capture;
  logic          beat;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        // An out-of-range start index is accepted but produces no beats.
        if (in_valid && (start_idx < N_IDX)) next_state = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready && (idx == LAST_IDX)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign capture = in_valid && in_ready;
  assign beat    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
      for (int i = 0; i < N; i++) arr[i] <= '0;
    end else if (capture) begin
      arr <= in;
      idx <= start_idx;
    end else if (beat) begin
      idx <= idx + IW'(1);
    end
  end

  assign out_data = out_valid ? arr[idx[OW-1:0]] : '0;
  assign out_idx  = out_valid ? idx[OW-1:0] : '0;

`ifdef MANTLE_GET_IDX_LAST_EN
  assign out_last = out_valid && (idx == LAST_IDX);
`endif

endmodule

// File: tb/tb_mantle_get_idx_stream.sv
// Directed self-checking bench for mantle_get_idx_stream (also covers MANTLE_GET_IDX_LAST_EN builds).
module tb_mantle_get_idx_stream;
  import mantle_pkg::*;

  localparam int N  = 9;
  localparam int W  = 32;
  localparam int IW = $clog2(N + 1);
  localparam int OW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_arr [N];
  logic [IW-1:0] start_idx;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic [OW-1:0] out_idx;
  logic          out_valid;
  logic          out_ready;
  state_t        state;
`ifdef MANTLE_GET_IDX_LAST_EN
  logic          out_last;
`endif

  logic [W-1:0]  mdl [N];
  int            errors = 0;
  int            checks = 0;
  int            beats;

  mantle_get_idx_stream #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in_arr),
    .start_idx (start_idx),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MANTLE_GET_IDX_LAST_EN
    .out_last  (out_last),
`endif
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, 64'(state), 64'(IDLE));
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
`ifdef MANTLE_GET_IDX_LAST_EN
    check({tag, "_out_last"}, 64'(out_last), 64'd0);
`endif
  endtask

  // Present the array for one cycle, then scramble the input to prove it was latched.
  task automatic capture(input int first);
    in_arr    = mdl;
    start_idx = IW'(first);
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) in_arr[i] = $urandom;
  endtask

  // Consume beats from `first` to N-1, stalling stall_cycles at stall_idx.
  task automatic run_stream(input string tag, input int first, input int stall_idx,
                            input int stall_cycles, output int nbeats);
    int exp_i   = first;
    int stalled = 0;
    nbeats = 0;
    for (int c = 0; c < 80 && exp_i < N; c++) begin
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_idx"}, 64'(out_idx), 64'(exp_i));
      check({tag, "_data"}, 64'(out_data), 64'(mdl[exp_i]));
      check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
`ifdef MANTLE_GET_IDX_LAST_EN
      check({tag, "_last"}, 64'(out_last), 64'(exp_i == N - 1));
`endif
      if (exp_i == stall_idx && stalled < stall_cycles) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) nbeats++;
      step();
      if (out_ready) exp_i++;
    end
    check({tag, "_timeout"}, 64'(exp_i), 64'(N));
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start_idx = '0;
    for (int i = 0; i < N; i++) in_arr[i] = '1;
    step();
    step();
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check_idle("rst");
    rst_n = 1'b1;
    step();
    check_idle("post_rst");

    // Full stream from index 0.
    for (int k = 0; k < N; k++) mdl[k] = W'(k * 32'h11);
    capture(0);
    run_stream("full", 0, -1, 0, beats);
    check("full_beats", 64'(beats), 64'd9);
    check_idle("full_end");

    // Offset start: only the last two elements.
    for (int k = 0; k < N; k++) mdl[k] = W'(32'hA000 + k);
    mdl[7] = 32'hDEADBEEF;
    mdl[8] = 32'h1;
    capture(7);
    run_stream("offset", 7, -1, 0, beats);
    check("offset_beats", 64'(beats), 64'd2);
    check_idle("offset_end");

    // Backpressure for 5 cycles at index 3.
    for (int k = 0; k < N; k++) mdl[k] = W'(32'h100 + k * 3);
    capture(0);
    run_stream("bp", 0, 3, 5, beats);
    check("bp_beats", 64'(beats), 64'd9);
    check_idle("bp_end");

    // Stall on the final beat (out_last must stay high in the macro build).
    for (int k = 0; k < N; k++) mdl[k] = W'(32'h5A5A0000 | k);
    capture(0);
    run_stream("last_stall", 0, 8, 3, beats);
    check("last_stall_beats", 64'(beats), 64'd9);
    check_idle("last_stall_end");

    // Out-of-range start index: accepted, nothing emitted.
    for (int k = 0; k < N; k++) mdl[k] = W'(32'hBEEF0000 | k);
    in_arr    = mdl;
    start_idx = IW'(9);
    in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("oor_in_ready", 64'(in_ready), 64'd1);
      step();
      check_idle("oor");
    end
    in_valid = 1'b0;
    step();
    check_idle("oor_after");

    // Reset mid-stream after the idx=4 beat.
    for (int k = 0; k < N; k++) mdl[k] = W'(32'hC0DE0000 + k);
    capture(0);
    for (int k = 0; k < 5; k++) begin
      check("mid_idx", 64'(out_idx), 64'(k));
      check("mid_data", 64'(out_data), 64'(mdl[k]));
      step();
    end
    check("mid_pre_rst_idx", 64'(out_idx), 64'd5);
    rst_n = 1'b0;
    step();
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_out_idx", 64'(out_idx), 64'd0);
    check_idle("mid_rst");
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check_idle("mid_after");
    end

    // A fresh capture still works after the aborted one.
    for (int k = 0; k < N; k++) mdl[k] = W'(32'h77 * (k + 1));
    capture(4);
    run_stream("recover", 4, -1, 0, beats);
    check("recover_beats", 64'(beats), 64'd5);
    check_idle("recover_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
